// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults, redirect kinds and the
// pending-redirect state encoding.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_J,
    RD_JR
  } rd_kind_e;

  typedef enum logic {
    IDLE,
    PEND
  } pend_state_e;

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC target select: computes branch/jump/jr targets from the D-stage PC
// and picks the highest-priority request (jr > j > branch).
module npc
  import mips_pkg::*;
(
  input  logic [31:0] base_pc,
  input  logic        br_taken,
  input  logic [31:0] br_off,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output rd_kind_e    kind,
  output logic [31:0] target
);

  logic [31:0] pc4;

  always_comb begin
    pc4    = base_pc + 32'd4;
    kind   = RD_NONE;
    target = pc4;
    if (jr_en) begin
      kind   = RD_JR;
      target = jr_target;
    end else if (j_en) begin
      kind   = RD_J;
      target = {pc4[31:28], j_index, 2'b00};
    end else if (br_taken) begin
      kind   = RD_BR;
      target = pc4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, pending-redirect register and F/D
// register. Define DELAY_SLOT_EN to keep the delay-slot instruction instead of flushing it.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_off,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_in,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_valid,
  output logic        redirect_pend
);

  rd_kind_e    live_kind;
  logic [31:0] live_tgt;
  logic        live;

  pend_state_e state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic [31:0] pc_next;
  logic        flush;

  npc u_npc (
    .base_pc   (d_pc),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .j_en      (j_en),
    .j_index   (j_index),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .kind      (live_kind),
    .target    (live_tgt)
  );

  assign live = (live_kind != RD_NONE);

  // A stalled redirect is parked; the latest one overwrites any earlier one.
  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      IDLE: begin
        if (stall && live) begin
          state_d    = PEND;
          pend_tgt_d = live_tgt;
        end
      end
      PEND: begin
        if (!stall) begin
          state_d = IDLE;
        end else if (live) begin
          pend_tgt_d = live_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A live redirect in the release cycle wins over the parked target.
  always_comb begin
    pc_next = f_pc + 32'd4;
    if (live)
      pc_next = live_tgt;
    else if (state_q == PEND)
      pc_next = pend_tgt_q;
  end

`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = live || (state_q == PEND);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_tgt_q <= '0;
      f_pc       <= RESET_PC;
      d_instr    <= NOP_WORD;
      d_pc       <= RESET_PC;
      d_valid    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      if (!stall) begin
        f_pc <= pc_next;
        d_pc <= f_pc;
        if (flush) begin
          d_instr <= NOP_WORD;
          d_valid <= 1'b0;
        end else begin
          d_instr <= instr_in;
          d_valid <= 1'b1;
        end
      end
    end
  end

  assign redirect_pend = (state_q == PEND);

endmodule
